msg_scheduler: RTL and testbench
================================

# msg_scheduler

Arbitrates outbound session-message requests (logon, logout, heartbeat, resend request) from the session manager into the single create-message engine. Each request class has its own FIFO. One request at a time is issued under fixed priority. The block waits for the engine to complete before issuing the next request, so requests raised while the engine is busy are held rather than lost.

## Interface
- NUM_HOST, 10: width of the host identifier (session table address).
- VALUE_WIDTH, 256: width of TargetCompID.
- QDEPTH, 4: entries per class FIFO; power of two, ≥2.
- TIMEOUT, 1024: cycles to wait for `cm_done_i` before abandoning an issued message.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-low.
- req_valid_i  in  1  request strobe, one request per cycle.
- req_type_i  in  4  1=logon, 2=heartbeat, 3=resendReq, 4=logout.
- req_host_i  in  NUM_HOST  target session.
- req_compid_i  in  VALUE_WIDTH  TargetCompID for the request.
- cm_busy_i  in  1  create-message engine busy.
- cm_done_i  in  1  one-cycle pulse: engine finished the current message.
- create_message_o  out  4  type of the issued message.
- host_o  out  NUM_HOST  host of the issued message.
- targetCompId_o  out  VALUE_WIDTH  TargetCompID of the issued message.
- initiate_msg_o  out  1  one-cycle issue pulse.
- drop_o  out  1  one-cycle pulse: request discarded (class FIFO full, or type invalid).
- timeout_o  out  1  one-cycle pulse: `cm_done_i` was not received within TIMEOUT cycles.
- busy_o  out  1  high while the FSM is in WAIT.

## Operation
- Enqueue:
  - On `req_valid_i`, `{host, compid}` is pushed into the FIFO selected by `req_type_i`.
  - A type outside 1..4 is not pushed; `drop_o` pulses.
  - A full target FIFO discards the request; `drop_o` pulses.
  - The full check uses the pre-edge occupancy. A simultaneous pop from the same FIFO does not make room.
- Priority: logon > logout > resendReq > heartbeat. Priority is fixed and non-preemptive.
- FSM state IDLE:
  - Issue condition: at least one FIFO is non-empty and `cm_busy_i`=0.
  - When the condition holds, pop the head of the highest-priority non-empty FIFO.
  - Register `create_message_o`, `host_o` and `targetCompId_o` from that entry.
  - Pulse `initiate_msg_o`, clear the timeout counter, and go to WAIT.
- FSM state WAIT:
  - Outputs hold their values. The counter increments each cycle.
  - If `cm_done_i`=1, go to IDLE.
  - Otherwise, when the counter reaches TIMEOUT-1, pulse `timeout_o` and go to IDLE.
  - If `cm_done_i` and the timeout condition occur in the same cycle, `cm_done_i` wins and there is no `timeout_o`.
- `cm_done_i` received in IDLE is ignored.
- `create_message_o`, `host_o` and `targetCompId_o` keep the last issued values in IDLE until the next issue.
- Timeout counter width: $clog2(TIMEOUT); it saturates and never wraps.

## Timing
- Reset values:
  - all outputs are 0;
  - all FIFOs are empty;
  - the FSM is in IDLE;
  - the counter is 0.
- Reset mid-WAIT abandons the in-flight message. No `timeout_o` is generated for it.
- Latency: a request accepted at edge k causes `initiate_msg_o` to be high for the cycle after edge k+1, provided the FSM is idle and `cm_busy_i`=0. There is no bypass path.
- Throughput: at most one issue per IDLE→WAIT→IDLE round trip. Minimum spacing between issues is 3 cycles when `cm_done_i` arrives the cycle after issue.
- `drop_o` is registered. It is high the cycle after the offending `req_valid_i`.
- FIFO wrap: read and write pointers are log2(QDEPTH)+1 bits wide. The extra MSB distinguishes full from empty.

## Structure
- Package `fix_session_pkg`:
  - message-type constants (logon=1, heartbeat=2, resendReq=3, logout=4), shared with `session_manager` and create_message;
  - FSM state enum {IDLE, WAIT}.
- Sub-module `sync_fifo` (parameters: width, depth), with push, pop, full, empty and head outputs. It is instantiated four times, with width NUM_HOST+VALUE_WIDTH.
- Top level contains: type decode, priority encoder, FSM, timeout counter, output registers.

## Test plan
- Single heartbeat, host 5, while idle:
  - `initiate_msg_o` pulses one cycle after acceptance;
  - `create_message_o`=2 and `host_o`=5 for that issue;
  - `cm_done_i` returns the FSM to IDLE.
- Logon (host 1), heartbeat (host 2) and logout (host 3) queued while `cm_busy_i`=1; then `cm_busy_i` is released:
  - issue order is types 1, 4, 2;
  - each issue follows the `cm_done_i` of the previous one.
- Five logons pushed with QDEPTH=4 and the FSM held off:
  - the fifth request is dropped and `drop_o` pulses once;
  - exactly four logons issue afterwards.
- `req_type_i`=7: `drop_o` pulses; nothing is queued or issued.
- Issue with no `cm_done_i`, TIMEOUT=16:
  - `timeout_o` pulses 16 cycles after the issue;
  - the FSM is in IDLE, and the next queued entry issues on the following cycle.
- Reset (`rst`=0) during WAIT with 2 entries queued:
  - all outputs are 0 and FIFOs are empty after the edge;
  - no issue happens until a new request arrives.

Source files
------------

// File: rtl/fix_session_pkg.sv
// Shared FIX session definitions: message-type codes and scheduler FSM states.
package fix_session_pkg;

  localparam logic [3:0] MSG_LOGON      = 4'd1;
  localparam logic [3:0] MSG_HEARTBEAT  = 4'd2;
  localparam logic [3:0] MSG_RESEND_REQ = 4'd3;
  localparam logic [3:0] MSG_LOGOUT     = 4'd4;

  typedef enum logic {
    IDLE,
    WAIT
  } state_t;

  // Class FIFO index doubles as priority rank (0 = highest).
  localparam logic [1:0] CLS_LOGON     = 2'd0;
  localparam logic [1:0] CLS_LOGOUT    = 2'd1;
  localparam logic [1:0] CLS_RESEND    = 2'd2;
  localparam logic [1:0] CLS_HEARTBEAT = 2'd3;

  function automatic logic [3:0] class_to_type(input logic [1:0] cls);
    case (cls)
      CLS_LOGON:  return MSG_LOGON;
      CLS_LOGOUT: return MSG_LOGOUT;
      CLS_RESEND: return MSG_RESEND_REQ;
      default:    return MSG_HEARTBEAT;
    endcase
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with extra-MSB pointers to tell full from empty.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head  = mem[rd_ptr[AW-1:0]];

  // Pointer update; overflowing pushes and underflowing pops are ignored.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full)  wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop  && !empty) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage write.
  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/msg_scheduler.sv
// Queues session-message requests per class and issues them one at a time,
// in fixed priority, to the create-message engine.
module msg_scheduler
  import fix_session_pkg::*;
#(
  parameter int NUM_HOST    = 10,
  parameter int VALUE_WIDTH = 256,
  parameter int QDEPTH      = 4,
  parameter int TIMEOUT     = 1024
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid_i,
  input  logic [3:0]             req_type_i,
  input  logic [NUM_HOST-1:0]    req_host_i,
  input  logic [VALUE_WIDTH-1:0] req_compid_i,
  input  logic                   cm_busy_i,
  input  logic                   cm_done_i,
  output logic [3:0]             create_message_o,
  output logic [NUM_HOST-1:0]    host_o,
  output logic [VALUE_WIDTH-1:0] targetCompId_o,
  output logic                   initiate_msg_o,
  output logic                   drop_o,
  output logic                   timeout_o,
  output logic                   busy_o
);

  localparam int DW = NUM_HOST + VALUE_WIDTH;
  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  logic [3:0]    full;
  logic [3:0]    empty;
  logic [3:0]    push;
  logic [3:0]    pop;
  logic [DW-1:0] head [4];
  logic [DW-1:0] din;

  logic [1:0]    in_cls;
  logic          type_ok;
  logic          reject;
  logic [1:0]    sel;
  logic          any_ready;

  state_t        state, state_next;
  logic [CW-1:0] cnt, cnt_next;
  logic          issue;
  logic          fire_to;

  assign din    = {req_host_i, req_compid_i};
  assign busy_o = (state == WAIT);

  for (genvar g = 0; g < 4; g++) begin : g_fifo
    sync_fifo #(
      .WIDTH(DW),
      .DEPTH(QDEPTH)
    ) u_fifo (
      .clk  (clk),
      .rst  (rst),
      .push (push[g]),
      .pop  (pop[g]),
      .din  (din),
      .full (full[g]),
      .empty(empty[g]),
      .head (head[g])
    );
  end

  // Type decode: route the request to its class FIFO or flag it for drop.
  always_comb begin
    in_cls  = CLS_LOGON;
    type_ok = 1'b0;
    push    = '0;
    case (req_type_i)
      MSG_LOGON:      begin in_cls = CLS_LOGON;     type_ok = 1'b1; end
      MSG_LOGOUT:     begin in_cls = CLS_LOGOUT;    type_ok = 1'b1; end
      MSG_RESEND_REQ: begin in_cls = CLS_RESEND;    type_ok = 1'b1; end
      MSG_HEARTBEAT:  begin in_cls = CLS_HEARTBEAT; type_ok = 1'b1; end
      default:        ;
    endcase
    // Full is the pre-edge occupancy, so a same-cycle pop never makes room.
    reject = req_valid_i && !(type_ok && !full[in_cls]);
    if (req_valid_i && type_ok && !full[in_cls]) push[in_cls] = 1'b1;
  end

  // Priority encoder over the class FIFOs (lowest index wins).
  always_comb begin
    any_ready = ~&empty;
    if (!empty[0])      sel = 2'd0;
    else if (!empty[1]) sel = 2'd1;
    else if (!empty[2]) sel = 2'd2;
    else                sel = 2'd3;
  end

  // Next-state, pop and timeout decision.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    issue      = 1'b0;
    fire_to    = 1'b0;
    pop        = '0;
    case (state)
      IDLE: begin
        if (any_ready && !cm_busy_i) begin
          issue      = 1'b1;
          pop[sel]   = 1'b1;
          cnt_next   = '0;
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (cm_done_i) begin
          state_next = IDLE;
        end else if (cnt == CNT_LAST) begin
          fire_to    = 1'b1;
          state_next = IDLE;
        end else if (cnt != '1) begin
          cnt_next = cnt + CW'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State, counter and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state            <= IDLE;
      cnt              <= '0;
      create_message_o <= '0;
      host_o           <= '0;
      targetCompId_o   <= '0;
      initiate_msg_o   <= 1'b0;
      drop_o           <= 1'b0;
      timeout_o        <= 1'b0;
    end else begin
      state          <= state_next;
      cnt            <= cnt_next;
      initiate_msg_o <= issue;
      timeout_o      <= fire_to;
      drop_o         <= reject;
      if (issue) begin
        create_message_o         <= class_to_type(sel);
        {host_o, targetCompId_o} <= head[sel];
      end
    end
  end

endmodule

// File: tb/tb_msg_scheduler.sv
// Self-checking bench for msg_scheduler: queue-based reference model feeds a
// scoreboard that a negedge monitor drains whenever the DUT issues.
module tb_msg_scheduler;

  localparam int NH = 10;
  localparam int VW = 64;
  localparam int QD = 4;
  localparam int TO = 16;

  logic          clk;
  logic          rst;
  logic          req_valid_i;
  logic [3:0]    req_type_i;
  logic [NH-1:0] req_host_i;
  logic [VW-1:0] req_compid_i;
  logic          cm_busy_i;
  logic          cm_done_i;
  logic [3:0]    create_message_o;
  logic [NH-1:0] host_o;
  logic [VW-1:0] targetCompId_o;
  logic          initiate_msg_o;
  logic          drop_o;
  logic          timeout_o;
  logic          busy_o;

  msg_scheduler #(
    .NUM_HOST(NH),
    .VALUE_WIDTH(VW),
    .QDEPTH(QD),
    .TIMEOUT(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req_valid_i(req_valid_i),
    .req_type_i(req_type_i),
    .req_host_i(req_host_i),
    .req_compid_i(req_compid_i),
    .cm_busy_i(cm_busy_i),
    .cm_done_i(cm_done_i),
    .create_message_o(create_message_o),
    .host_o(host_o),
    .targetCompId_o(targetCompId_o),
    .initiate_msg_o(initiate_msg_o),
    .drop_o(drop_o),
    .timeout_o(timeout_o),
    .busy_o(busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]    t;
    logic [NH-1:0] h;
    logic [VW-1:0] c;
  } ent_t;

  ent_t pend[$];   // accepted, not yet issued, in arrival order
  ent_t exp_q[$];  // scoreboard of expected issues
  ent_t ne;
  ent_t got;

  int checks = 0;
  int errors = 0;
  bit mon_en = 0;
  int done_mode = 0;  // 0: never, 1: done right after issue, 2: random

  bit            m_wait = 0;
  int            m_cnt = 0;
  int            occ;
  bit            found;
  int            prio [4] = '{1, 4, 3, 2};
  bit            e_init = 0, e_drop = 0, e_to = 0, e_busy = 0;
  logic [3:0]    e_type = '0;
  logic [NH-1:0] e_host = '0;
  logic [VW-1:0] e_comp = '0;

  task automatic chk(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: per-edge behaviour derived from the scheduling rules.
  always @(posedge clk) begin
    if (!rst) begin
      pend.delete();
      exp_q.delete();
      m_wait = 0; m_cnt = 0;
      e_init = 0; e_drop = 0; e_to = 0; e_busy = 0;
      e_type = '0; e_host = '0; e_comp = '0;
    end else begin
      e_init = 0; e_drop = 0; e_to = 0;
      occ = 0;
      foreach (pend[i]) if (pend[i].t == req_type_i) occ++;
      if (!m_wait) begin
        if (pend.size() != 0 && !cm_busy_i) begin
          found = 0;
          for (int p = 0; p < 4 && !found; p++)
            for (int i = 0; i < pend.size() && !found; i++)
              if (pend[i].t == 4'(prio[p])) begin
                e_type = pend[i].t; e_host = pend[i].h; e_comp = pend[i].c;
                exp_q.push_back(pend[i]);
                pend.delete(i);
                found = 1;
              end
          e_init = 1; m_wait = 1; m_cnt = 0;
        end
      end else if (cm_done_i) begin
        m_wait = 0;
      end else if (m_cnt == TO - 1) begin
        m_wait = 0; e_to = 1;
      end else begin
        m_cnt++;
      end
      if (req_valid_i) begin
        if (req_type_i >= 4'd1 && req_type_i <= 4'd4 && occ < QD) begin
          ne.t = req_type_i; ne.h = req_host_i; ne.c = req_compid_i;
          pend.push_back(ne);
        end else begin
          e_drop = 1;
        end
      end
      e_busy = m_wait;
    end
  end

  // Monitor: per-cycle strobes plus scoreboard pop on every issue.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("initiate", initiate_msg_o, e_init);
      chk("drop", drop_o, e_drop);
      chk("timeout", timeout_o, e_to);
      chk("busy", busy_o, e_busy);
      chk("held_type", create_message_o, e_type);
      chk("held_host", host_o, e_host);
      chk("held_compid", targetCompId_o, e_comp);
      if (initiate_msg_o) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL issue_unexpected actual=type %0d required=no issue", create_message_o);
        end else begin
          got = exp_q.pop_front();
          chk("issue_type", create_message_o, got.t);
          chk("issue_host", host_o, got.h);
          chk("issue_compid", targetCompId_o, got.c);
        end
      end
    end
  end

  // Engine responder.
  always @(negedge clk) begin
    case (done_mode)
      1:       cm_done_i = initiate_msg_o;
      2:       cm_done_i = ($urandom_range(0, 3) == 0);
      default: cm_done_i = 1'b0;
    endcase
  end

  task automatic req(input logic [3:0] t, input logic [NH-1:0] h);
    @(negedge clk);
    req_valid_i = 1'b1; req_type_i = t; req_host_i = h;
    req_compid_i = {$urandom, $urandom};
    @(negedge clk);
    req_valid_i = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst = 1'b0; req_valid_i = 1'b0; req_type_i = '0; req_host_i = '0;
    req_compid_i = '0; cm_busy_i = 1'b0;
    cycles(2);
    chk("reset_type", create_message_o, 0);
    chk("reset_host", host_o, 0);
    chk("reset_initiate", initiate_msg_o, 0);
    rst = 1'b1; mon_en = 1;

    // Single heartbeat while idle.
    done_mode = 1;
    req(4'd2, 10'd5);
    cycles(6);

    // Three classes queued behind a busy engine.
    cm_busy_i = 1'b1;
    req(4'd1, 10'd1); req(4'd2, 10'd2); req(4'd4, 10'd3);
    cm_busy_i = 1'b0;
    cycles(12);

    // Overfill the logon FIFO.
    cm_busy_i = 1'b1;
    repeat (5) req(4'd1, 10'($urandom));
    cm_busy_i = 1'b0;
    cycles(20);

    // Invalid type.
    req(4'd7, 10'd9);
    cycles(4);

    // Timeouts back to back.
    done_mode = 0;
    req(4'd2, 10'd11); req(4'd3, 10'd12);
    cycles(40);

    // Reset during WAIT with two entries queued.
    req(4'd1, 10'd20); req(4'd4, 10'd21); req(4'd3, 10'd22);
    @(negedge clk); rst = 1'b0;
    @(negedge clk); rst = 1'b1;
    chk("rst_mid_type", create_message_o, 0);
    chk("rst_mid_host", host_o, 0);
    chk("rst_mid_busy", busy_o, 0);
    cycles(10);

    // Randomized traffic.
    done_mode = 2;
    for (int n = 0; n < 1500; n++) begin
      @(negedge clk);
      req_valid_i  = 1'($urandom_range(0, 1));
      req_type_i   = 4'($urandom_range(0, 5));
      req_host_i   = NH'($urandom);
      req_compid_i = {$urandom, $urandom};
      cm_busy_i    = ($urandom_range(0, 4) == 0);
    end
    @(negedge clk);
    req_valid_i = 1'b0; cm_busy_i = 1'b0; done_mode = 1;
    cycles(60);
    chk("scoreboard_drained", 64'(exp_q.size()), 0);
    chk("model_drained", 64'(pend.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
